button_press_decoder: RTL

Consumer-side companion of `button_deb`: takes the debounced level `button_valid` and turns it into one-cycle event pulses. A press is classified as short, long, or double. The block sits between `button_deb` and user logic such as menus and mode selects. All timing is in milliseconds, derived from a 1 ms prescaler clocked by the system clock.

---
 rtl/button_press_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/button_press_decoder.sv
// button_press_decoder: turns a debounced button level into short/long/double press pulses.
// Latency: pulses are registered and appear on the clock edge that detects the qualifying event.
// Backpressure: none; every pulse is a one-cycle strobe that the consumer must sample.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   button_valid  debounced button level (1 = pressed), synchronous to clk
//   short_press   one-cycle pulse when a single short press completes (gap timeout)
//   long_press    one-cycle pulse when a hold reaches LONG_PRESS_MS
//   double_press  one-cycle pulse on release of the second press of a double press
//   busy          high whenever the decoder is not idle
module button_press_decoder #(
  parameter int CLK_FREQ      = 95_000,  // clock cycles per ms
  parameter int LONG_PRESS_MS = 1000,
  parameter int DOUBLE_GAP_MS = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic button_valid,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam int PRE_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int MS_MAX = (LONG_PRESS_MS > DOUBLE_GAP_MS) ? LONG_PRESS_MS : DOUBLE_GAP_MS;
  localparam int MS_W   = $clog2(MS_MAX + 1);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_FREQ - 1);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [MS_W-1:0]  MS_SAT    = MS_W'(MS_MAX);
  localparam logic [MS_W-1:0]  MS_ONE    = MS_W'(1);
  localparam logic [MS_W-1:0]  LONG_LAST = MS_W'(LONG_PRESS_MS - 1);
  localparam logic [MS_W-1:0]  GAP_LAST  = MS_W'(DOUBLE_GAP_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_LONG_HELD,
    S_WAIT_GAP,
    S_PRESS2
  } state_t;

  state_t           state_q, state_d;
  logic             prev_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             busy_q, busy_d;

  logic rise, fall, tick;

  assign rise = button_valid & ~prev_q;
  assign fall = ~button_valid & prev_q;
  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    // Restarting the prescaler on every edge keeps ms thresholds exact relative to that edge.
    if (rise || fall || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_ONE;
    end

    // Edges are tested before timeouts so a coincident edge always wins.
    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (fall) begin
          state_d = S_WAIT_GAP;
        end else if (tick && ms_q == LONG_LAST) begin
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (fall) state_d = S_IDLE;
      end
      S_WAIT_GAP: begin
        if (rise) begin
          state_d = S_PRESS2;
        end else if (tick && ms_q == GAP_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_PRESS2: begin
        if (fall) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ms counter restarts on every state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      ms_d = '0;
    end else if (tick && ms_q != MS_SAT) begin
      ms_d = ms_q + MS_ONE;
    end else begin
      ms_d = ms_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      prev_q   <= 1'b0;
      pre_q    <= '0;
      ms_q     <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= button_valid;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign busy         = busy_q;

endmodule
